// File: rtl/doctor_move_scheduler.sv
// Turns the four raw direction keys into one frame-stable movement command for the
// doctor movement block, with last-pressed-wins turn buffering and a post-collision block timer.
module doctor_move_scheduler #(
    parameter int unsigned BLOCK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       game_enable,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_right,
    input  logic       key_left,
    input  logic       collision,
    input  logic [3:0] HitEdgeCode,
    output logic       Up_Move,
    output logic       Down_Move,
    output logic       Right_Move,
    output logic       Left_Move,
    output logic [1:0] move_dir,
    output logic       move_valid,
    output logic       blocked
);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_IDLE,
        ST_MOVE,
        ST_BLOCKED
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] dir_reg, dir_next;
    logic       pend_valid_reg, pend_valid_next;
    logic [1:0] pend_dir_reg, pend_dir_next;
    logic       mask_valid_reg, mask_valid_next;
    logic [1:0] mask_dir_reg, mask_dir_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] keys_prev_reg;
    logic [3:0] move_vec_reg;
    logic       move_valid_reg;
    logic       blocked_reg;

    // Bit index equals the direction code: 0 up, 1 down, 2 right, 3 left.
    logic [3:0] keys;
    logic [3:0] rise;
    logic [3:0] usable;
    logic [1:0] rise_dir;
    logic       pend_valid_eff;
    logic [1:0] pend_dir_eff;
    logic       mask_valid_eff;
    logic       has_cur;
    logic       sel_valid;
    logic [1:0] sel_dir;
    logic [1:0] edge_idx;
    logic       head_on;
    logic       do_select;

    assign keys = {key_left, key_right, key_down, key_up};
    assign rise = keys & ~keys_prev_reg;

    // A direction may be chosen only if its key is held and it is not the masked one.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_usable
            assign usable[gi] = keys[gi] & ~(mask_valid_eff & (mask_dir_reg == 2'(gi)));
        end
    endgenerate

    always_comb begin
        rise_dir = 2'd3;
        if (rise[0])      rise_dir = 2'd0;
        else if (rise[1]) rise_dir = 2'd1;
        else if (rise[2]) rise_dir = 2'd2;

        // Same-cycle key edges are visible to a selection happening in this cycle.
        pend_valid_eff = pend_valid_reg | (|rise);
        pend_dir_eff   = (|rise) ? rise_dir : pend_dir_reg;
        mask_valid_eff = mask_valid_reg & ~rise[mask_dir_reg];
    end

    always_comb begin
        has_cur   = (state_reg == ST_MOVE) || (state_reg == ST_BLOCKED);
        sel_valid = 1'b1;
        sel_dir   = 2'd0;
        if (pend_valid_eff && usable[pend_dir_eff]) sel_dir = pend_dir_eff;
        else if (has_cur && usable[dir_reg])        sel_dir = dir_reg;
        else if (usable[0])                         sel_dir = 2'd0;
        else if (usable[1])                         sel_dir = 2'd1;
        else if (usable[2])                         sel_dir = 2'd2;
        else if (usable[3])                         sel_dir = 2'd3;
        else                                        sel_valid = 1'b0;
    end

    always_comb begin
        case (dir_reg)
            2'd0:    edge_idx = 2'd2;
            2'd1:    edge_idx = 2'd0;
            2'd2:    edge_idx = 2'd1;
            default: edge_idx = 2'd3;
        endcase
        head_on = collision & HitEdgeCode[edge_idx];
    end

    always_comb begin
        state_next      = state_reg;
        dir_next        = dir_reg;
        pend_valid_next = pend_valid_eff;
        pend_dir_next   = pend_dir_eff;
        mask_valid_next = mask_valid_eff;
        mask_dir_next   = mask_dir_reg;
        cnt_next        = cnt_reg;
        do_select       = 1'b0;

        if (!game_enable) begin
            state_next      = ST_DISABLED;
            pend_valid_next = 1'b0;
            mask_valid_next = 1'b0;
            cnt_next        = 4'd0;
        end else begin
            case (state_reg)
                ST_DISABLED: begin
                    state_next      = ST_IDLE;
                    pend_valid_next = 1'b0;
                    mask_valid_next = 1'b0;
                end
                ST_IDLE, ST_MOVE: begin
                    if (state_reg == ST_MOVE && head_on) begin
                        state_next      = ST_BLOCKED;
                        cnt_next        = 4'(BLOCK_FRAMES);
                        mask_dir_next   = dir_reg;
                        mask_valid_next = 1'b1;
                    end else if (startOfFrame) begin
                        do_select = 1'b1;
                    end
                end
                default: begin
                    if (startOfFrame) begin
                        if (cnt_reg <= 4'd1) do_select = 1'b1;
                        else                 cnt_next = cnt_reg - 4'd1;
                    end
                end
            endcase
        end

        if (do_select) begin
            pend_valid_next = 1'b0;
            cnt_next        = 4'd0;
            if (sel_valid) begin
                state_next = ST_MOVE;
                dir_next   = sel_dir;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            dir_reg        <= 2'd0;
            pend_valid_reg <= 1'b0;
            pend_dir_reg   <= 2'd0;
            mask_valid_reg <= 1'b0;
            mask_dir_reg   <= 2'd0;
            cnt_reg        <= 4'd0;
            keys_prev_reg  <= 4'd0;
            move_vec_reg   <= 4'd0;
            move_valid_reg <= 1'b0;
            blocked_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dir_reg        <= dir_next;
            pend_valid_reg <= pend_valid_next;
            pend_dir_reg   <= pend_dir_next;
            mask_valid_reg <= mask_valid_next;
            mask_dir_reg   <= mask_dir_next;
            cnt_reg        <= cnt_next;
            keys_prev_reg  <= keys;
            move_vec_reg   <= (state_next == ST_MOVE) ? (4'd1 << dir_next) : 4'd0;
            move_valid_reg <= (state_next == ST_MOVE);
            blocked_reg    <= (state_next == ST_BLOCKED);
        end
    end

    assign Up_Move    = move_vec_reg[0];
    assign Down_Move  = move_vec_reg[1];
    assign Right_Move = move_vec_reg[2];
    assign Left_Move  = move_vec_reg[3];
    assign move_dir   = dir_reg;
    assign move_valid = move_valid_reg;
    assign blocked    = blocked_reg;

endmodule

// File: tb/tb_doctor_move_scheduler.sv
// Bench for doctor_move_scheduler: directed scenarios followed by random key/frame/collision
// traffic, every cycle compared against a behavioural model of the scheduling rules.
module tb_doctor_move_scheduler;

    localparam int N = 4;
    localparam logic [3:0] K_UP = 4'b0001, K_DOWN = 4'b0010, K_RIGHT = 4'b0100, K_LEFT = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame, game_enable, collision;
    logic       key_up, key_down, key_right, key_left;
    logic [3:0] HitEdgeCode;
    logic       Up_Move, Down_Move, Right_Move, Left_Move;
    logic [1:0] move_dir;
    logic       move_valid, blocked;

    int checks = 0;
    int errors = 0;

    doctor_move_scheduler #(.BLOCK_FRAMES(N)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .game_enable(game_enable),
        .key_up(key_up), .key_down(key_down), .key_right(key_right), .key_left(key_left),
        .collision(collision), .HitEdgeCode(HitEdgeCode),
        .Up_Move(Up_Move), .Down_Move(Down_Move), .Right_Move(Right_Move), .Left_Move(Left_Move),
        .move_dir(move_dir), .move_valid(move_valid), .blocked(blocked)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 disabled, 1 idle, 2 moving, 3 blocked.
    int   m_mode, m_dir, m_pend_d, m_mask_d, m_cnt;
    bit   m_pend_v, m_mask_v;
    bit   m_prev [4];
    int   head_edge [4] = '{2, 0, 1, 3};

    task automatic model_reset();
        m_mode = 1; m_dir = 0; m_pend_v = 0; m_pend_d = 0;
        m_mask_v = 0; m_mask_d = 0; m_cnt = 0;
        foreach (m_prev[i]) m_prev[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] k, input bit sof, en, coll, input logic [3:0] hit);
        bit pv, mv, found;
        int pd, pick;
        int cands[$];
        pv = m_pend_v; pd = m_pend_d; mv = m_mask_v;
        for (int i = 3; i >= 0; i--)
            if (k[i] && !m_prev[i]) begin pv = 1; pd = i; end
        if (mv && k[m_mask_d] && !m_prev[m_mask_d]) mv = 0;

        if (!en) begin
            m_mode = 0; pv = 0; mv = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; pv = 0; mv = 0;
        end else if (m_mode == 2 && coll && hit[head_edge[m_dir]]) begin
            m_mode = 3; m_cnt = N; m_mask_d = m_dir; mv = 1;
        end else if (sof && (m_mode != 3 || m_cnt <= 1)) begin
            if (pv) cands.push_back(pd);
            if (m_mode >= 2) cands.push_back(m_dir);
            for (int d = 0; d < 4; d++) cands.push_back(d);
            found = 0; pick = 0;
            foreach (cands[j])
                if (!found && k[cands[j]] && !(mv && cands[j] == m_mask_d)) begin
                    found = 1; pick = cands[j];
                end
            if (found) begin m_mode = 2; m_dir = pick; end
            else m_mode = 1;
            pv = 0; m_cnt = 0;
        end else if (sof && m_mode == 3) begin
            m_cnt--;
        end
        m_pend_v = pv; m_pend_d = pd; m_mask_v = mv;
        for (int i = 0; i < 4; i++) m_prev[i] = k[i];
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic [3:0] exp_vec;
        exp_vec = (m_mode == 2) ? (4'd1 << m_dir) : 4'd0;
        check("outputs", {2'b0, Left_Move, Right_Move, Down_Move, Up_Move, move_valid, blocked},
              {2'b0, exp_vec, (m_mode == 2) ? 1'b1 : 1'b0, (m_mode == 3) ? 1'b1 : 1'b0});
        if (m_mode == 2) check("move_dir", {6'b0, move_dir}, 8'(m_dir));
    endtask

    // Inputs change at the falling edge; outputs are compared at the next falling edge.
    task automatic step(input logic [3:0] k, input bit sof, input bit en = 1,
                        input bit coll = 0, input logic [3:0] hit = 4'b0);
        {key_left, key_right, key_down, key_up} = k;
        startOfFrame = sof; game_enable = en; collision = coll; HitEdgeCode = hit;
        model_step(k, sof, en, coll, hit);
        @(posedge clk);
        @(negedge clk);
        compare_model();
        $display("[%0t] keys=%b sof=%b en=%b coll=%b hit=%b -> moves=%b valid=%b dir=%0d blocked=%b",
                 $time, k, sof, en, coll, hit, {Left_Move, Right_Move, Down_Move, Up_Move},
                 move_valid, move_dir, blocked);
    endtask

    task automatic frame_gap(input logic [3:0] k);
        step(k, 0); step(k, 0);
    endtask

    initial begin
        reset = 1'b1;
        {key_left, key_right, key_down, key_up} = 4'b0;
        startOfFrame = 0; game_enable = 1; collision = 0; HitEdgeCode = 4'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {2'b0, Left_Move, Right_Move, Down_Move, Up_Move, move_valid, blocked}, 8'h00);
        check("reset_move_dir", {6'b0, move_dir}, 8'h00);
        reset = 1'b0;

        // Up held, then a frame pulse.
        step(K_UP, 0);
        check("up_before_frame", {7'b0, Up_Move}, 8'h00);
        step(K_UP, 1);
        check("up_after_frame", {5'b0, Up_Move, move_dir}, 8'h04);
        frame_gap(K_UP);

        // Moving right, left pressed mid-frame while right still held.
        step(K_RIGHT, 0); step(K_RIGHT, 1); frame_gap(K_RIGHT);
        step(K_RIGHT | K_LEFT, 0); frame_gap(K_RIGHT | K_LEFT);
        step(K_RIGHT | K_LEFT, 1);
        check("last_pressed_wins", {6'b0, Left_Move, Right_Move}, 8'h02);

        // Simultaneous up/down/left rise.
        step(0, 1); frame_gap(0);
        step(K_UP | K_DOWN | K_LEFT, 0);
        step(K_UP | K_DOWN | K_LEFT, 1);
        check("same_cycle_priority", {4'b0, Left_Move, Right_Move, Down_Move, Up_Move}, 8'h01);

        // Head-on collision while moving left, then masked expiry and re-press.
        step(K_LEFT, 0); step(K_LEFT, 1);
        step(K_LEFT, 0, 1, 1, 4'b1000);
        check("blocked_after_hit", {6'b0, Left_Move, blocked}, 8'h01);
        for (int p = 0; p < N; p++) begin
            frame_gap(K_LEFT);
            step(K_LEFT, 1);
        end
        check("masked_idle", {6'b0, move_valid, blocked}, 8'h00);
        step(0, 0); step(K_LEFT, 0); step(K_LEFT, 1);
        check("repress_unmasks", {7'b0, Left_Move}, 8'h01);

        // Side-edge collision is ignored.
        step(K_UP, 0); step(K_UP, 1);
        step(K_UP, 0, 1, 1, 4'b0010);
        check("side_hit_ignored", {6'b0, Up_Move, blocked}, 8'h02);

        // Collision and frame pulse in the same cycle: that pulse does not count.
        step(K_UP, 1, 1, 1, 4'b0100);
        check("hit_beats_frame", {7'b0, blocked}, 8'h01);
        for (int p = 0; p < N - 1; p++) begin
            frame_gap(K_UP);
            step(K_UP, 1);
        end
        check("still_blocked", {7'b0, blocked}, 8'h01);
        frame_gap(K_UP); step(K_UP, 1);
        check("released_to_idle", {7'b0, blocked}, 8'h00);

        // Disable while blocked clears the mask.
        step(K_DOWN, 0); step(K_DOWN, 1);
        step(K_DOWN, 0, 1, 1, 4'b0001);
        step(K_DOWN, 0, 0);
        check("disabled_outputs", {6'b0, move_valid, blocked}, 8'h00);
        step(K_DOWN, 0, 1); step(K_DOWN, 1, 1);
        check("mask_cleared", {7'b0, Down_Move}, 8'h01);

        // Asynchronous reset in the middle of BLOCKED.
        step(K_DOWN, 0, 1, 1, 4'b0001); step(K_DOWN, 1);
        #2 reset = 1'b1;
        #1 check("async_reset", {6'b0, move_valid, blocked}, 8'h00);
        model_reset();
        @(negedge clk) reset = 1'b0;
        step(K_DOWN, 0); step(K_DOWN, 1);

        // Random traffic.
        begin
            logic [3:0] k;
            bit en;
            k = K_DOWN; en = 1;
            for (int c = 0; c < 1200; c++) begin
                if ($urandom_range(0, 5) == 0) k[$urandom_range(0, 3)] ^= 1'b1;
                if ($urandom_range(0, 99) < 2) en = ~en;
                else if (!en && $urandom_range(0, 9) == 0) en = 1;
                step(k, (c % 6) == 5, en, $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
